// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing, playfield geometry and RGB332 colour constants
// for the snake display stage.
package vga_pkg;

  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FRONT      = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BACK       = 10'd48;
  localparam logic [9:0] H_SYNC_START = 10'd656;
  localparam logic [9:0] H_SYNC_END   = 10'd752;
  localparam logic [9:0] H_TOTAL      = 10'd800;
  localparam logic [9:0] H_LAST       = 10'd799;

  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FRONT      = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BACK       = 10'd33;
  localparam logic [9:0] V_SYNC_START = 10'd490;
  localparam logic [9:0] V_SYNC_END   = 10'd492;
  localparam logic [9:0] V_TOTAL      = 10'd525;
  localparam logic [9:0] V_LAST       = 10'd524;

  localparam logic [9:0] GRID_W     = 10'd30;
  localparam logic [9:0] GRID_CELLS = 10'd900;
  localparam logic [9:0] GRID_PIX   = 10'd480;

  localparam logic [7:0] BLANK       = 8'h00;
  localparam logic [7:0] BACKGROUND  = 8'h00;
  localparam logic [7:0] SNAKE_COLOR = 8'b00011000;
  localparam logic [7:0] FOOD_COLOR  = 8'b00010011;
  localparam logic [7:0] BORDER      = 8'b01001001;
  localparam logic [7:0] BORDER_LOST = 8'b11100000;
  localparam logic [7:0] BORDER_WON  = 8'b00011100;

  // A lost game dominates a won flag so a glitchy double-assert still reads as loss.
  function automatic logic [7:0] border_color(input logic lost, input logic won);
    if (lost)     return BORDER_LOST;
    else if (won) return BORDER_WON;
    else          return BORDER;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel-clock divider, 800x525 raster counters, raw sync/visible decode of the
// current position and a one-cycle pulse after each frame wrap.
module vga_timing
  import vga_pkg::*;
#(
  parameter int PIX_DIV = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic       pt_o,
  output logic [9:0] h_o,
  output logic [9:0] v_o,
  output logic       hsync_n_o,
  output logic       vsync_n_o,
  output logic       visible_o,
  output logic       frame_tick_o
);

  localparam int            DW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d, v_q, v_d;
  logic          frame_tick_q, frame_tick_d;
  logic          pt, h_wrap, v_wrap;

  always_comb begin
    pt     = (div_q == DIV_LAST);
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    div_d  = pt ? '0 : div_q + DW'(1);
    h_d    = h_q;
    v_d    = v_q;
    if (pt) begin
      h_d = h_wrap ? 10'd0 : h_q + 10'd1;
      if (h_wrap) v_d = v_wrap ? 10'd0 : v_q + 10'd1;
    end
    frame_tick_d = pt && h_wrap && v_wrap;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q        <= '0;
      h_q          <= 10'd0;
      v_q          <= 10'd0;
      frame_tick_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      h_q          <= h_d;
      v_q          <= v_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign pt_o         = pt;
  assign h_o          = h_q;
  assign v_o          = v_q;
  assign hsync_n_o    = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
  assign vsync_n_o    = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
  assign visible_o    = (h_q < H_VISIBLE) && (v_q < V_VISIBLE);
  assign frame_tick_o = frame_tick_q;

endmodule

// File: rtl/vga_grid_renderer.sv
// Maps the raster position to a 30x30 grid cell index for the game logic and
// registers sync plus colour together so they leave the block one pixel late.
module vga_grid_renderer
  import vga_pkg::*;
#(
  parameter int PIX_DIV    = 4,
  parameter int GRID_X0    = 80,
  parameter int CELL_SHIFT = 4,
  parameter int NO_CELL    = 1023
) (
  input  logic       master_clk,
  input  logic       rst,
  output logic [9:0] index,
  input  logic       is_snake,
  input  logic       is_food,
  input  logic       won,
  input  logic       lost,
  output logic       hsync,
  output logic       vsync,
  output logic [7:0] rgb,
  output logic       frame_tick
);

  localparam logic [9:0] GX0    = 10'(GRID_X0);
  localparam logic [9:0] GX_END = 10'(GRID_X0 + 480);

  logic       pt, hsync_n, vsync_n, visible;
  logic [9:0] h, v;
  logic [9:0] h_off, col, row;
  logic       in_grid;
  logic [7:0] rgb_d, rgb_q;
  logic       hsync_q, vsync_q;

  vga_timing #(
    .PIX_DIV (PIX_DIV)
  ) u_timing (
    .clk_i        (master_clk),
    .rst_i        (rst),
    .pt_o         (pt),
    .h_o          (h),
    .v_o          (v),
    .hsync_n_o    (hsync_n),
    .vsync_n_o    (vsync_n),
    .visible_o    (visible),
    .frame_tick_o (frame_tick)
  );

  // row*30 tops out at 870, so the 10-bit product never overflows.
  always_comb begin
    h_off   = h - GX0;
    in_grid = (h >= GX0) && (h < GX_END) && (v < GRID_PIX);
    col     = h_off >> CELL_SHIFT;
    row     = v >> CELL_SHIFT;
    index   = in_grid ? (row * GRID_W + col) : 10'(NO_CELL);
  end

  always_comb begin
    rgb_d = BACKGROUND;
    if (!visible)      rgb_d = BLANK;
    else if (!in_grid) rgb_d = border_color(lost, won);
    else if (is_snake) rgb_d = SNAKE_COLOR;
    else if (is_food)  rgb_d = FOOD_COLOR;
  end

  always_ff @(posedge master_clk) begin
    if (rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 8'h00;
    end else if (pt) begin
      hsync_q <= hsync_n;
      vsync_q <= vsync_n;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign rgb   = rgb_q;

endmodule
